// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per (file,reg) pending bit plus latency countdown, driving RAW/WAW stalls in DEC.
// Optional stall statistics counter is built only when HAZARD_SCOREBOARD_STATS_EN is defined.
module hazard_scoreboard #(
    parameter int  NUM_REGS  = 32,
    parameter int  NUM_FILES = 2,
    parameter int  MAX_LAT   = 7,
    localparam int RA_W      = $clog2(NUM_REGS),
    localparam int FI_W      = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1,
    localparam int LAT_W     = $clog2(MAX_LAT + 1),
    localparam int CNT_W     = $clog2(NUM_REGS * NUM_FILES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_we,
    input  logic [RA_W-1:0]  issue_rd,
    input  logic [FI_W-1:0]  issue_file,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             src1_used,
    input  logic [RA_W-1:0]  src1_addr,
    input  logic [FI_W-1:0]  src1_file,
    input  logic             src2_used,
    input  logic [RA_W-1:0]  src2_addr,
    input  logic [FI_W-1:0]  src2_file,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [FI_W-1:0]  wb_file,
    output logic             stall,
    output logic             src1_ready,
    output logic             src2_ready,
    output logic [CNT_W-1:0] pending_count,
    output logic [31:0]      stall_cycles
);

    // Entries are addressed as {file, reg}; slots for files beyond NUM_FILES are never written.
    localparam int EI_W = FI_W + RA_W;
    localparam int NE   = 2 ** EI_W;

    logic             pend [NE];
    logic [LAT_W-1:0] cnt  [NE];

    logic [EI_W-1:0]  iss_idx, src1_idx, src2_idx, wb_idx;
    logic [LAT_W-1:0] lat_eff;
    logic             waw, accept, wb_clear, cnt_inc, cnt_dec;

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        if (lat == '0 || int'(lat) > MAX_LAT)
            return LAT_W'(MAX_LAT);
        return lat;
    endfunction

    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] c);
        return (c == '0) ? c : c - LAT_W'(1);
    endfunction

    function automatic logic file_ok(input logic [FI_W-1:0] f);
        return int'(f) < NUM_FILES;
    endfunction

    function automatic logic is_zero_reg(input logic [FI_W-1:0] f, input logic [RA_W-1:0] a);
        return (f == '0) && (a == '0);
    endfunction

    assign iss_idx  = {issue_file, issue_rd};
    assign src1_idx = {src1_file, src1_addr};
    assign src2_idx = {src2_file, src2_addr};
    assign wb_idx   = {wb_file, wb_rd};
    assign lat_eff  = clamp_lat(issue_lat);

    always_comb begin
        src1_ready = !src1_used || is_zero_reg(src1_file, src1_addr) || !file_ok(src1_file)
                     || !pend[src1_idx] || (cnt[src1_idx] == '0);
        src2_ready = !src2_used || is_zero_reg(src2_file, src2_addr) || !file_ok(src2_file)
                     || !pend[src2_idx] || (cnt[src2_idx] == '0);

        // A younger write may not land before an older one to the same register.
        waw = issue_we && file_ok(issue_file) && pend[iss_idx] && (cnt[iss_idx] > lat_eff);

        stall  = issue_valid && !flush && (!src1_ready || !src2_ready || waw);
        accept = issue_valid && !stall && !flush && issue_we && file_ok(issue_file)
                 && !is_zero_reg(issue_file, issue_rd);

        // An accept to the same entry overrides the writeback clear.
        wb_clear = wb_valid && file_ok(wb_file) && pend[wb_idx] && !(accept && (wb_idx == iss_idx));

        cnt_inc = accept && !pend[iss_idx];
        cnt_dec = wb_clear;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) begin
                pend[i] <= 1'b0;
                cnt[i]  <= '0;
            end
            pending_count <= '0;
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (accept && (i == int'(iss_idx))) begin
                    pend[i] <= 1'b1;
                    cnt[i]  <= lat_eff;
                end else if (wb_clear && (i == int'(wb_idx))) begin
                    pend[i] <= 1'b0;
                    cnt[i]  <= '0;
                end else if (pend[i]) begin
                    cnt[i] <= sat_dec(cnt[i]);
                end
            end
            case ({cnt_inc, cnt_dec})
                2'b10:   pending_count <= pending_count + CNT_W'(1);
                2'b01:   pending_count <= pending_count - CNT_W'(1);
                default: pending_count <= pending_count;
            endcase
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

`ifndef SYNTHESIS
    lat_legal: assert property (@(posedge clk) disable iff (rst)
        (issue_valid && issue_we && !flush) |-> ((issue_lat != '0) && (int'(issue_lat) <= MAX_LAT)));
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random traffic, checked against a
// timestamp-based model (each pending register remembers the absolute cycle its result becomes ready).
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int NF = 2;
    localparam int ML = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_we;
    logic [4:0]  issue_rd;
    logic [0:0]  issue_file;
    logic [2:0]  issue_lat;
    logic        src1_used, src2_used;
    logic [4:0]  src1_addr, src2_addr;
    logic [0:0]  src1_file, src2_file;
    logic        flush, wb_valid;
    logic [4:0]  wb_rd;
    logic [0:0]  wb_file;
    logic        stall, src1_ready, src2_ready;
    logic [6:0]  pending_count;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(NR), .NUM_FILES(NF), .MAX_LAT(ML)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .issue_file(issue_file), .issue_lat(issue_lat),
        .src1_used(src1_used), .src1_addr(src1_addr), .src1_file(src1_file),
        .src2_used(src2_used), .src2_addr(src2_addr), .src2_file(src2_file),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_file(wb_file),
        .stall(stall), .src1_ready(src1_ready), .src2_ready(src2_ready),
        .pending_count(pending_count), .stall_cycles(stall_cycles)
    );

    int n_cmp = 0;
    int n_err = 0;

    bit mp [NF][NR];
    int rdy_at [NF][NR];
    int now = 0;
    int m_stalls = 0;

    function automatic int m_c(int f, int r);
        if (!mp[f][r]) return 0;
        return (rdy_at[f][r] - now > 0) ? rdy_at[f][r] - now : 0;
    endfunction

    function automatic bit m_ready(bit used, int f, int a);
        return !used || (f == 0 && a == 0) || (m_c(f, a) == 0);
    endfunction

    function automatic bit m_stall();
        bit waw;
        waw = issue_we && mp[int'(issue_file)][int'(issue_rd)]
              && (m_c(int'(issue_file), int'(issue_rd)) > int'(issue_lat));
        return issue_valid && !flush
               && (!m_ready(src1_used, int'(src1_file), int'(src1_addr))
                   || !m_ready(src2_used, int'(src2_file), int'(src2_addr)) || waw);
    endfunction

    function automatic int m_pending();
        int n = 0;
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < NR; r++)
                n += int'(mp[f][r]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        bit s, acc;
        int exp_sc;
        #1;
        s = m_stall();
`ifdef HAZARD_SCOREBOARD_STATS_EN
        exp_sc = m_stalls;
`else
        exp_sc = 0;
`endif
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".rdy1"}, 32'(src1_ready), 32'(m_ready(src1_used, int'(src1_file), int'(src1_addr))));
        chk({tag, ".rdy2"}, 32'(src2_ready), 32'(m_ready(src2_used, int'(src2_file), int'(src2_addr))));
        chk({tag, ".pcnt"}, 32'(pending_count), 32'(m_pending()));
        chk({tag, ".scyc"}, stall_cycles, 32'(exp_sc));
        acc = issue_valid && !s && !flush && issue_we && !(issue_file == 0 && issue_rd == 0);
        @(posedge clk);
        if (rst) begin
            for (int f = 0; f < NF; f++)
                for (int r = 0; r < NR; r++)
                    mp[f][r] = 1'b0;
            m_stalls = 0;
        end else begin
            if (s) m_stalls++;
            if (wb_valid) mp[int'(wb_file)][int'(wb_rd)] = 1'b0;
            if (acc) begin
                mp[int'(issue_file)][int'(issue_rd)] = 1'b1;
                rdy_at[int'(issue_file)][int'(issue_rd)] = now + 1 + int'(issue_lat);
            end
        end
        now++;
        @(negedge clk);
    endtask

    task automatic set_issue(input bit v, input bit we, input int f, input int rd, input int lat);
        issue_valid = v;
        issue_we    = we;
        issue_file  = 1'(f);
        issue_rd    = 5'(rd);
        issue_lat   = 3'(lat);
    endtask

    task automatic set_src(input int n, input bit used, input int f, input int a);
        if (n == 1) begin
            src1_used = used; src1_file = 1'(f); src1_addr = 5'(a);
        end else begin
            src2_used = used; src2_file = 1'(f); src2_addr = 5'(a);
        end
    endtask

    task automatic set_wb(input bit v, input int f, input int r);
        wb_valid = v;
        wb_file  = 1'(f);
        wb_rd    = 5'(r);
    endtask

    task automatic idle();
        set_issue(0, 0, 0, 0, 1);
        set_src(1, 0, 0, 0);
        set_src(2, 0, 0, 0);
        set_wb(0, 0, 0);
        flush = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        repeat (2) tick("reset");
        rst = 1'b0;
        repeat (4) tick("idle");

        // RAW on int x5
        set_issue(1, 1, 0, 5, 3);
        tick("iss_x5");
        set_issue(1, 0, 0, 0, 1);
        set_src(1, 1, 0, 5);
        repeat (5) tick("raw_x5");
        idle();
        tick("idle1");

        // Integer and float files are independent
        set_issue(1, 1, 1, 5, 4);
        tick("iss_f5");
        set_issue(1, 0, 0, 0, 1);
        set_src(1, 1, 0, 5);
        tick("sep_x5");
        set_src(2, 1, 1, 5);
        repeat (4) tick("raw_f5");
        idle();
        tick("idle2");

        // WAW on x7: long write then short write
        set_issue(1, 1, 0, 7, 5);
        tick("iss_x7");
        set_issue(1, 1, 0, 7, 1);
        repeat (5) tick("waw_x7");
        idle();
        tick("idle3");

        // Writeback and accepted issue to the same pending entry
        set_issue(1, 1, 0, 5, 2);
        set_wb(1, 0, 5);
        tick("wb_iss_x5");
        idle();
        set_issue(1, 0, 0, 0, 1);
        set_src(1, 1, 0, 5);
        repeat (3) tick("post_wb_x5");
        idle();

        // Writebacks: pending entry, int x0, non-pending float entry
        set_wb(1, 0, 7);
        tick("wb_x7");
        set_wb(1, 0, 0);
        tick("wb_x0");
        set_wb(1, 1, 20);
        tick("wb_f20");
        idle();

        // Flush suppresses stall and entry creation
        set_issue(1, 1, 0, 9, 5);
        tick("iss_x9");
        set_issue(1, 1, 0, 10, 2);
        set_src(1, 1, 0, 9);
        flush = 1'b1;
        repeat (2) tick("flush_x9");
        flush = 1'b0;
        tick("unflush_x9");
        idle();

        // Reset in the middle of traffic
        set_issue(1, 1, 0, 3, 4);
        rst = 1'b1;
        tick("rst_mid");
        rst = 1'b0;
        idle();
        repeat (2) tick("after_rst");

        // Random traffic over a small register window to provoke hazards
        for (int k = 0; k < 400; k++) begin
            set_issue($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(1, ML)));
            set_src(1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            set_src(2, $urandom_range(0, 1) == 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            set_wb($urandom_range(0, 9) < 3, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick("rand");
        end
        rst = 1'b0;
        idle();
        tick("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
